// File: rtl/core5_pio_pkg.sv
// Shared register-map addresses and bus timing constants for the Core5 PIO blocks.
package core5_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int READ_LATENCY = 1;

endpackage

// File: rtl/core5_blink_prescaler.sv
// Blink timebase for the LED PIO: cnt runs 0..period and flips phase on wrap.
// Exposes the phase value for the coming edge so the owner can register outputs coherently.
module core5_blink_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                restart_i,
    output logic                phase_next_o
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // A zero period parks the engine; a restart wins over a wrap on the same edge.
    always_comb begin
        cnt_d   = cnt_q + CNT_ONE;
        phase_d = phase_q;
        if (restart_i || (period_i == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_i) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_next_o = phase_d;

endmodule

// File: rtl/core5_leds_pio.sv
// Avalon-MM output PIO driving board LEDs, with set/clear aliases and an optional blink engine.
// Blink engine, MASK and PERIOD registers exist only when CORE5_LEDS_BLINK_EN is defined.
module core5_leds_pio
    import core5_pio_pkg::*;
#(
    parameter int               WIDTH     = 18,
    parameter int               PERIOD_W  = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wrEn;
    logic [WIDTH-1:0] wrData;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] outport_q, outport_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wrEn   = chipselect && !write_n;
    assign wrData = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unusedHi
            logic unusedWriteBits;
            assign unusedWriteBits = ^writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (wrEn) begin
            case (address)
                ADDR_DATA:   data_d = wrData;
                ADDR_OUTSET: data_d = data_q | wrData;
                ADDR_OUTCLR: data_d = data_q & ~wrData;
                default:     data_d = data_q;
            endcase
        end
    end

`ifdef CORE5_LEDS_BLINK_EN
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                restart;
    logic                phaseNext;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        if (wrEn && (address == ADDR_MASK))   mask_d   = wrData;
        if (wrEn && (address == ADDR_PERIOD)) period_d = writedata[PERIOD_W-1:0];
    end

    assign restart = wrEn && (address == ADDR_PERIOD);

    core5_blink_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk          (clk),
        .reset_n      (reset_n),
        .period_i     (period_q),
        .restart_i    (restart),
        .phase_next_o (phaseNext)
    );

    // Uses next-state data, mask and phase so writes and toggles land on the same edge.
    assign outport_d = data_d & ~(mask_d & {WIDTH{phaseNext}});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end
`else
    assign outport_d = data_d;
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: readdata_d[WIDTH-1:0] = data_q;
`ifdef CORE5_LEDS_BLINK_EN
            ADDR_MASK:   readdata_d[WIDTH-1:0]    = mask_q;
            ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period_q;
`endif
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= RESET_VAL;
            outport_q  <= RESET_VAL;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            outport_q  <= outport_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = outport_q;

endmodule
